scanner_unit: RTL and testbench

//  - Single scanner node: on a local start command, fills an internal buffer in fixed

---
 rtl/scanner_pkg.sv | 25 ++
 rtl/scanner_if.sv | 22 ++
 rtl/scanner_serial_tx.sv | 52 +++++
 rtl/scanner_unit.sv | 82 ++++++++
 tb/tb_scanner_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/scanner_pkg.sv
// Shared definitions for the scanner node: state encodings, command codes and
// default sizing of the fill level and transmitted word.
package scanner_pkg;

    typedef enum logic [1:0] {
        STANDBY  = 2'b00,
        SCANNING = 2'b01,
        FULL     = 2'b10,
        TRANSFER = 2'b11
    } scan_state_t;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    localparam int FILL_STEP_DEF = 2;
    localparam int FILL_MAX_DEF  = 100;
    localparam int DATA_W_DEF    = 8;

    // Exact match: any X/Z bit in the command makes it read as "not this command".
    function automatic logic cmdIs(input logic [1:0] cmd, input logic [1:0] code);
        return (cmd === code);
    endfunction

endpackage

// File: rtl/scanner_if.sv
// Local control and serial-link signals of one scanner node; the master side
// drives the command and peer-ready inputs, the slave side is the node itself.
interface scanner_if;
    logic       readyForTransferIn;
    logic [1:0] localTransferInput;
    logic [1:0] ps;
    logic [7:0] outputDataBuffer;
    logic [7:0] outputBuffer;
    logic       clkOut;
    logic       dataOut;
    logic [3:0] dataBuffer;

    modport master (
        output readyForTransferIn, localTransferInput,
        input  ps, outputDataBuffer, outputBuffer, clkOut, dataOut, dataBuffer
    );

    modport slave (
        input  readyForTransferIn, localTransferInput,
        output ps, outputDataBuffer, outputBuffer, clkOut, dataOut, dataBuffer
    );
endinterface

// File: rtl/scanner_serial_tx.sv
// Bit-serial transmitter: latches a byte, then walks a 16-step half-bit counter
// presenting each bit MSB first for two clocks (strobe low, then strobe high).
module scanner_serial_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       run,
    input  logic [7:0] wordIn,
    output logic [7:0] wordReg,
    output logic [3:0] countReg,
    output logic       clkOutReg,
    output logic       dataOutReg,
    output logic       done
);
    logic [7:0] msbFirst;
    logic [3:0] countNext;

    // Bit-reversed view so the counter's upper bits index the MSB first.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rev
            assign msbFirst[gi] = wordReg[7 - gi];
        end
    endgenerate

    assign countNext = countReg + 4'd1;
    assign done      = run && (countReg == 4'hF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wordReg    <= '0;
            countReg   <= '0;
            clkOutReg  <= 1'b0;
            dataOutReg <= 1'b0;
        end else if (load) begin
            wordReg    <= wordIn;
            countReg   <= '0;
            clkOutReg  <= 1'b0;
            dataOutReg <= wordIn[7];
        end else if (run) begin
            if (countReg == 4'hF) begin
                countReg   <= '0;
                clkOutReg  <= 1'b0;
                dataOutReg <= 1'b0;
            end else begin
                countReg   <= countNext;
                clkOutReg  <= countNext[0];
                dataOutReg <= msbFirst[countNext[3:1]];
            end
        end
    end
endmodule

// File: rtl/scanner_unit.sv
// Scanner node: fills its buffer level in fixed steps on a start command, waits
// for the peer in FULL, then ships the latched level byte over the serial link.
module scanner_unit
    import scanner_pkg::*;
#(
    parameter int FILL_STEP = FILL_STEP_DEF,
    parameter int FILL_MAX  = FILL_MAX_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic     clk,
    input  logic     rst,
    scanner_if.slave bus
);
    scan_state_t       stateReg;
    logic [DATA_W-1:0] levelReg;
    logic [DATA_W-1:0] levelNext;
    logic              startCmd;
    logic              abortCmd;
    logic              peerReady;
    logic              txLoad;
    logic              txRun;
    logic              txDone;
    logic [7:0]        txWord;

    assign startCmd  = cmdIs(bus.localTransferInput, CMD_START);
    assign abortCmd  = cmdIs(bus.localTransferInput, CMD_ABORT);
    assign peerReady = (bus.readyForTransferIn === 1'b1);
    assign levelNext = levelReg + DATA_W'(FILL_STEP);
    assign txLoad    = (stateReg == FULL) && peerReady;
    assign txRun     = (stateReg == TRANSFER);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg <= STANDBY;
            levelReg <= '0;
        end else begin
            case (stateReg)
                STANDBY: begin
                    if (startCmd) stateReg <= SCANNING;
                end
                SCANNING: begin
                    if (abortCmd) begin
                        stateReg <= STANDBY;
                        levelReg <= '0;
                    end else begin
                        levelReg <= levelNext;
                        if (levelNext == DATA_W'(FILL_MAX)) stateReg <= FULL;
                    end
                end
                FULL: begin
                    if (peerReady) stateReg <= TRANSFER;
                end
                TRANSFER: begin
                    // The serial stream always runs to completion; inputs are ignored here.
                    if (txDone) begin
                        stateReg <= STANDBY;
                        levelReg <= '0;
                    end
                end
                default: stateReg <= STANDBY;
            endcase
        end
    end

    assign txWord = 8'(levelReg);

    scanner_serial_tx u_tx (
        .clk        (clk),
        .rst        (rst),
        .load       (txLoad),
        .run        (txRun),
        .wordIn     (txWord),
        .wordReg    (bus.outputDataBuffer),
        .countReg   (bus.dataBuffer),
        .clkOutReg  (bus.clkOut),
        .dataOutReg (bus.dataOut),
        .done       (txDone)
    );

    assign bus.ps           = stateReg;
    assign bus.outputBuffer = 8'(levelReg);
endmodule

// File: tb/tb_scanner_unit.sv
// Self-checking bench for scanner_unit: directed scenarios plus a randomized run
// compared against a mode/level/half-bit reference model.
module tb_scanner_unit;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Reference model: mode 0 standby, 1 scanning, 2 full, 3 transfer.
    int mMode, mLevel, mWord, mHalf;

    scanner_if bus ();

    scanner_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        mMode = 0; mLevel = 0; mWord = 0; mHalf = 0;
    endtask

    task automatic modelStep();
        int cmd;
        cmd = int'(bus.localTransferInput);
        case (mMode)
            0: if (cmd == 1) mMode = 1;
            1: begin
                if (cmd == 3) begin mMode = 0; mLevel = 0; end
                else begin
                    mLevel = mLevel + 2;
                    if (mLevel == 100) mMode = 2;
                end
            end
            2: if (bus.readyForTransferIn == 1'b1) begin mMode = 3; mWord = mLevel; mHalf = 0; end
            default: begin
                if (mHalf == 15) begin mMode = 0; mLevel = 0; mHalf = 0; end
                else mHalf = mHalf + 1;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst !== 1'b1) modelReset(); else modelStep();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.localTransferInput = 2'b00;
        bus.readyForTransferIn = 1'b0;
        modelReset();
        tick();
        checks += 6;
        if (bus.ps !== 2'b00) begin failures++; $display("FAIL reset_ps got=%b exp=00", bus.ps); end
        if (bus.outputBuffer !== 8'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.outputBuffer); end
        if (bus.outputDataBuffer !== 8'd0) begin failures++; $display("FAIL reset_word got=%0d exp=0", bus.outputDataBuffer); end
        if (bus.dataBuffer !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.dataBuffer); end
        if (bus.clkOut !== 1'b0) begin failures++; $display("FAIL reset_clkout got=%b exp=0", bus.clkOut); end
        if (bus.dataOut !== 1'b0) begin failures++; $display("FAIL reset_dataout got=%b exp=0", bus.dataOut); end
        $display("reset: ps=%b level=%0d", bus.ps, bus.outputBuffer);
    endtask

    task automatic test_scan();
        rst = 1'b1;
        bus.localTransferInput = 2'b01;
        tick();
        checks += 2;
        if (bus.ps !== 2'b01) begin failures++; $display("FAIL scan_enter_ps got=%b exp=01", bus.ps); end
        if (bus.outputBuffer !== 8'd0) begin failures++; $display("FAIL scan_enter_level got=%0d exp=0", bus.outputBuffer); end
        for (int i = 1; i <= 50; i++) begin
            logic [1:0] expPs;
            tick();
            expPs = (i == 50) ? 2'b10 : 2'b01;
            checks += 2;
            if (bus.outputBuffer !== 8'(2 * i)) begin failures++; $display("FAIL scan_level step=%0d got=%0d exp=%0d", i, bus.outputBuffer, 2 * i); end
            if (bus.ps !== expPs) begin failures++; $display("FAIL scan_ps step=%0d got=%b exp=%b", i, bus.ps, expPs); end
        end
        $display("scan: ps=%b level=%0d after 50 scanning clocks", bus.ps, bus.outputBuffer);
    endtask

    task automatic test_wait();
        bus.readyForTransferIn = 1'b0;
        bus.localTransferInput = 2'b11;   // abort must be ignored while FULL
        for (int i = 0; i < 8; i++) begin
            tick();
            checks += 2;
            if (bus.ps !== 2'b10) begin failures++; $display("FAIL wait_ps cyc=%0d got=%b exp=10", i, bus.ps); end
            if (bus.outputBuffer !== 8'd100) begin failures++; $display("FAIL wait_level cyc=%0d got=%0d exp=100", i, bus.outputBuffer); end
        end
        $display("wait: ps=%b level=%0d", bus.ps, bus.outputBuffer);
    endtask

    task automatic test_transfer();
        logic [7:0] expByte;
        logic [7:0] gotByte;
        int         nHigh;
        expByte = 8'b0110_0100;
        gotByte = 8'd0;
        nHigh   = 0;
        bus.localTransferInput = 2'b01;
        bus.readyForTransferIn = 1'b1;
        tick();
        bus.readyForTransferIn = 1'b0;
        checks += 2;
        if (bus.ps !== 2'b11) begin failures++; $display("FAIL xfer_ps got=%b exp=11", bus.ps); end
        if (bus.outputDataBuffer !== expByte) begin failures++; $display("FAIL xfer_word got=%b exp=%b", bus.outputDataBuffer, expByte); end
        for (int k = 0; k < 16; k++) begin
            checks += 3;
            if (bus.ps !== 2'b11) begin failures++; $display("FAIL xfer_hold_ps k=%0d got=%b exp=11", k, bus.ps); end
            if (bus.dataBuffer !== 4'(k)) begin failures++; $display("FAIL xfer_count k=%0d got=%0d exp=%0d", k, bus.dataBuffer, k); end
            if (bus.clkOut !== 1'(k % 2)) begin failures++; $display("FAIL xfer_clkout k=%0d got=%b exp=%0d", k, bus.clkOut, k % 2); end
            if (bus.clkOut === 1'b1) begin
                gotByte = {gotByte[6:0], bus.dataOut};
                nHigh++;
            end
            if (k < 15) tick();
        end
        checks += 2;
        if (nHigh !== 8) begin failures++; $display("FAIL xfer_strobes got=%0d exp=8", nHigh); end
        if (gotByte !== expByte) begin failures++; $display("FAIL xfer_serial got=%b exp=%b", gotByte, expByte); end
        tick();
        checks += 6;
        if (bus.ps !== 2'b00) begin failures++; $display("FAIL xfer_end_ps got=%b exp=00", bus.ps); end
        if (bus.outputBuffer !== 8'd0) begin failures++; $display("FAIL xfer_end_level got=%0d exp=0", bus.outputBuffer); end
        if (bus.dataBuffer !== 4'd0) begin failures++; $display("FAIL xfer_end_count got=%0d exp=0", bus.dataBuffer); end
        if (bus.clkOut !== 1'b0) begin failures++; $display("FAIL xfer_end_clkout got=%b exp=0", bus.clkOut); end
        if (bus.dataOut !== 1'b0) begin failures++; $display("FAIL xfer_end_dataout got=%b exp=0", bus.dataOut); end
        if (bus.outputDataBuffer !== expByte) begin failures++; $display("FAIL xfer_end_word got=%b exp=%b", bus.outputDataBuffer, expByte); end
        $display("transfer: serial=%b word=%b ps=%b", gotByte, bus.outputDataBuffer, bus.ps);
    endtask

    task automatic test_restart_abort();
        tick();   // start still held from the transfer
        checks += 2;
        if (bus.ps !== 2'b01) begin failures++; $display("FAIL restart_ps got=%b exp=01", bus.ps); end
        if (bus.outputBuffer !== 8'd0) begin failures++; $display("FAIL restart_level got=%0d exp=0", bus.outputBuffer); end
        repeat (5) tick();
        checks += 1;
        if (bus.outputBuffer !== 8'd10) begin failures++; $display("FAIL restart_progress got=%0d exp=10", bus.outputBuffer); end
        bus.localTransferInput = 2'b11;
        tick();
        checks += 2;
        if (bus.ps !== 2'b00) begin failures++; $display("FAIL abort_ps got=%b exp=00", bus.ps); end
        if (bus.outputBuffer !== 8'd0) begin failures++; $display("FAIL abort_level got=%0d exp=0", bus.outputBuffer); end
        bus.localTransferInput = 2'b10;   // reserved code acts as no command
        tick();
        checks += 1;
        if (bus.ps !== 2'b00) begin failures++; $display("FAIL reserved_ps got=%b exp=00", bus.ps); end
        $display("restart/abort: ps=%b level=%0d", bus.ps, bus.outputBuffer);
    endtask

    task automatic test_async_reset();
        int  budget;
        budget = 0;
        bus.localTransferInput = 2'b01;
        while (bus.ps !== 2'b10 && budget < 60) begin
            tick();
            budget++;
        end
        checks += 1;
        if (bus.ps !== 2'b10) begin failures++; $display("FAIL async_reach_full got=%b exp=10", bus.ps); end
        bus.readyForTransferIn = 1'b1;
        tick();
        bus.readyForTransferIn = 1'b0;
        repeat (3) tick();
        checks += 1;
        if (bus.ps !== 2'b11) begin failures++; $display("FAIL async_in_xfer got=%b exp=11", bus.ps); end
        #2 rst = 1'b0;
        #1;
        checks += 6;
        if (bus.ps !== 2'b00) begin failures++; $display("FAIL async_ps got=%b exp=00", bus.ps); end
        if (bus.outputBuffer !== 8'd0) begin failures++; $display("FAIL async_level got=%0d exp=0", bus.outputBuffer); end
        if (bus.outputDataBuffer !== 8'd0) begin failures++; $display("FAIL async_word got=%0d exp=0", bus.outputDataBuffer); end
        if (bus.dataBuffer !== 4'd0) begin failures++; $display("FAIL async_count got=%0d exp=0", bus.dataBuffer); end
        if (bus.clkOut !== 1'b0) begin failures++; $display("FAIL async_clkout got=%b exp=0", bus.clkOut); end
        if (bus.dataOut !== 1'b0) begin failures++; $display("FAIL async_dataout got=%b exp=0", bus.dataOut); end
        $display("async reset: ps=%b level=%0d count=%0d", bus.ps, bus.outputBuffer, bus.dataBuffer);
        bus.localTransferInput = 2'b00;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        modelReset();
        for (int n = 0; n < 3000; n++) begin
            int r;
            int expClk, expData, expCnt;
            r = int'($urandom_range(0, 99));
            if (r < 30)      bus.localTransferInput = 2'b01;
            else if (r < 31) bus.localTransferInput = 2'b11;
            else if (r < 40) bus.localTransferInput = 2'b10;
            else             bus.localTransferInput = 2'b00;
            bus.readyForTransferIn = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                modelReset();
            end else begin
                rst = 1'b1;
            end
            tick();
            expClk  = (mMode == 3) ? mHalf % 2 : 0;
            expData = (mMode == 3) ? (mWord >> (7 - mHalf / 2)) & 1 : 0;
            expCnt  = (mMode == 3) ? mHalf : 0;
            checks += 6;
            if (bus.ps !== 2'(mMode)) begin failures++; errs++; $display("FAIL rand_ps n=%0d got=%b exp=%0d", n, bus.ps, mMode); end
            if (bus.outputBuffer !== 8'(mLevel)) begin failures++; errs++; $display("FAIL rand_level n=%0d got=%0d exp=%0d", n, bus.outputBuffer, mLevel); end
            if (bus.outputDataBuffer !== 8'(mWord)) begin failures++; errs++; $display("FAIL rand_word n=%0d got=%0d exp=%0d", n, bus.outputDataBuffer, mWord); end
            if (bus.dataBuffer !== 4'(expCnt)) begin failures++; errs++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, bus.dataBuffer, expCnt); end
            if (bus.clkOut !== 1'(expClk)) begin failures++; errs++; $display("FAIL rand_clkout n=%0d got=%b exp=%0d", n, bus.clkOut, expClk); end
            if (bus.dataOut !== 1'(expData)) begin failures++; errs++; $display("FAIL rand_dataout n=%0d got=%b exp=%0d", n, bus.dataOut, expData); end
        end
        rst = 1'b1;
        $display("random: 3000 cycles, %0d discrepancies", errs);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        bus.localTransferInput = 2'b00;
        bus.readyForTransferIn = 1'b0;
        @(negedge clk);
        test_reset();
        test_scan();
        test_wait();
        test_transfer();
        test_restart_abort();
        test_async_reset();
        test_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
